// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of dmem_arbiter.
//
//   Requester N (N = 0 CPU load/store unit, N = 1 debug/DMA):
//     rN_req, rN_we, rN_size, rN_sext, rN_addr, rN_wdata  -> arbiter
//     rN_gnt (combinational), rN_rvalid, rN_rdata         <- arbiter
//   Memory (32-bit words, one-cycle registered read):
//     mem_write_en, mem_write_addr, mem_write_data        <- arbiter
//     mem_read_addr                                       <- arbiter
//     mem_read_data                                       -> arbiter
//
//   modport slave  : the arbiter's view.
//   modport master : the environment's view (requesters plus memory).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        r0_req;
    logic        r0_we;
    logic [1:0]  r0_size;
    logic        r0_sext;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_gnt;
    logic        r0_rvalid;
    logic [31:0] r0_rdata;

    logic        r1_req;
    logic        r1_we;
    logic [1:0]  r1_size;
    logic        r1_sext;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_gnt;
    logic        r1_rvalid;
    logic [31:0] r1_rdata;

    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;

    modport slave (
        input  r0_req, r0_we, r0_size, r0_sext, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_size, r1_sext, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_write_en, mem_write_addr, mem_write_data, mem_read_addr,
        input  mem_read_data
    );

    modport master (
        output r0_req, r0_we, r0_size, r0_sext, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_size, r1_sext, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_write_en, mem_write_addr, mem_write_data, mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Round-robin arbiter and access sequencer between two requesters and a
//   word-organised data memory. Word stores complete in the grant cycle; loads
//   take one extra cycle for lane extraction (optional sign extension);
//   byte/halfword stores are done as read-modify-write over two cycles.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; forces all outputs to 0 while high
//     bus    dmem_arbiter_if.slave (requester ports and memory port)
// -----------------------------------------------------------------------------
module dmem_arbiter (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;        // port granted most recently
    logic        port_q, port_d;        // port owning the access in flight
    logic        sext_q, sext_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        any_req;
    logic        sel;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [1:0]  gnt;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;

    // Little-endian lane extraction; size[1] set means a full word.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (size[1])
            r = word;
        else if (size[0])
            r = {{16{sext & h[15]}}, h};
        else
            r = {{24{sext & b[7]}}, b};
        return r;
    endfunction

    // Insert right-aligned store data into the addressed lane(s) of a word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (size[1])
            r = wdata;
        else if (size[0]) begin
            if (off[1])
                r[31:16] = wdata[15:0];
            else
                r[15:0] = wdata[15:0];
        end else
            r[{off, 3'b000} +: 8] = wdata[7:0];
        return r;
    endfunction

    // Arbitration: a lone requester wins; under contention the port not
    // granted last wins.
    always_comb begin
        any_req = bus.r0_req | bus.r1_req;
        if (bus.r0_req && bus.r1_req)
            sel = ~last_q;
        else
            sel = bus.r1_req;
        req_we    = sel ? bus.r1_we    : bus.r0_we;
        req_size  = sel ? bus.r1_size  : bus.r0_size;
        req_sext  = sel ? bus.r1_sext  : bus.r0_sext;
        req_addr  = sel ? bus.r1_addr  : bus.r0_addr;
        req_wdata = sel ? bus.r1_wdata : bus.r0_wdata;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        sext_d    = sext_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rvalid_d  = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt       = 2'b00;
        mem_we    = 1'b0;
        mem_waddr = 32'h0;
        mem_wdata = 32'h0;
        mem_raddr = 32'h0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt[sel] = 1'b1;
                    last_d   = sel;
                    port_d   = sel;
                    sext_d   = req_sext;
                    size_d   = req_size;
                    addr_d   = req_addr;
                    if (req_we && !req_size[1])
                        wdata_d = req_wdata;
                    if (req_we && req_size[1]) begin
                        // Full-word store goes straight to memory.
                        mem_we    = 1'b1;
                        mem_waddr = req_addr;
                        mem_wdata = req_wdata;
                    end else begin
                        mem_raddr = req_addr;
                        state_d   = req_we ? RMW : LOAD;
                    end
                end
            end
            LOAD: begin
                if (port_q)
                    rdata1_d = extract_lane(bus.mem_read_data, size_q, addr_q[1:0], sext_q);
                else
                    rdata0_d = extract_lane(bus.mem_read_data, size_q, addr_q[1:0], sext_q);
                rvalid_d[port_q] = 1'b1;
                state_d          = IDLE;
            end
            RMW: begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = merge_lanes(bus.mem_read_data, wdata_q, size_q, addr_q[1:0]);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
        port_q  <= port_d;
        sext_q  <= sext_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Reset masks every output combinationally, including registered ones
    // that were set by the edge that entered reset.
    assign bus.r0_gnt         = gnt[0] & ~reset;
    assign bus.r1_gnt         = gnt[1] & ~reset;
    assign bus.r0_rvalid      = rvalid_q[0] & ~reset;
    assign bus.r1_rvalid      = rvalid_q[1] & ~reset;
    assign bus.r0_rdata       = reset ? 32'h0 : rdata0_q;
    assign bus.r1_rdata       = reset ? 32'h0 : rdata1_q;
    assign bus.mem_write_en   = mem_we & ~reset;
    assign bus.mem_write_addr = reset ? 32'h0 : mem_waddr;
    assign bus.mem_write_data = reset ? 32'h0 : mem_wdata;
    assign bus.mem_read_addr  = reset ? 32'h0 : mem_raddr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter: a word memory model, a transaction-level reference
//   (reference memory, grant rule, response timing) checked every cycle, plus
//   directed scenarios and randomized traffic on both ports.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference lane arithmetic: byte count and offset from the size code.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic [31:0] a, input logic sext);
        int nb, off;
        logic [31:0] m, v;
        nb  = nbytes(size);
        off = (nb == 4) ? 0 : (int'(a[1:0]) / nb) * nb;
        m   = lane_mask(nb);
        v   = (w >> (8 * off)) & m;
        if (sext && nb < 4 && v[8 * nb - 1])
            v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] a, input logic [31:0] wd);
        int nb, off;
        logic [31:0] sm;
        nb  = nbytes(size);
        off = (nb == 4) ? 0 : (int'(a[1:0]) / nb) * nb;
        sm  = lane_mask(nb) << (8 * off);
        return (w & ~sm) | ((wd << (8 * off)) & sm);
    endfunction

    // Memory: write at the edge, registered read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_write_en) begin
            mem[bus.mem_write_addr[9:2]] <= bus.mem_write_data;
        end
        bus.mem_read_data <= mem[bus.mem_read_addr[9:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          cyc = 0;
    logic        m_last;
    int          next_free;
    logic        pl_v = 1'b0;
    int          pl_due;
    logic        pl_port;
    logic [31:0] pl_data;
    logic        pw_v = 1'b0;
    int          pw_due;
    logic [31:0] pw_addr, pw_data;
    logic [31:0] m_rd0, m_rd1;
    logic        log_en = 1'b0;
    int          g_port_q[$];
    int          g_cyc_q[$];

    initial begin : monitor
        logic [1:0]  req, gv, rv;
        logic        gp, g_we, g_sext, ew;
        logic [1:0]  g_size;
        logic [31:0] g_addr, g_wd, ewa, ewd;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_clear)
                for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            if (reset) begin
                check_val("rst_ctl", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.mem_write_en}, 5'b0);
                check_val("rst_mem", {bus.mem_write_addr, bus.mem_write_data, bus.mem_read_addr}, 96'b0);
                check_val("rst_rdata", {bus.r1_rdata, bus.r0_rdata}, 64'b0);
                pl_v = 1'b0; pw_v = 1'b0; m_last = 1'b1; next_free = cyc + 1;
                m_rd0 = 32'h0; m_rd1 = 32'h0;
            end else begin
                req = {bus.r1_req, bus.r0_req};
                gv = 2'b00; gp = 1'b0;
                if (cyc >= next_free && req != 2'b00) begin
                    gp = (req == 2'b11) ? ~m_last : req[1];
                    gv[gp] = 1'b1;
                end
                check_val("gnt", {bus.r1_gnt, bus.r0_gnt}, gv);
                g_we   = gp ? bus.r1_we    : bus.r0_we;
                g_size = gp ? bus.r1_size  : bus.r0_size;
                g_sext = gp ? bus.r1_sext  : bus.r0_sext;
                g_addr = gp ? bus.r1_addr  : bus.r0_addr;
                g_wd   = gp ? bus.r1_wdata : bus.r0_wdata;

                ew = 1'b0; ewa = 32'h0; ewd = 32'h0;
                if (pw_v && pw_due == cyc) begin
                    ew = 1'b1; ewa = pw_addr; ewd = pw_data; pw_v = 1'b0;
                end else if (gv != 2'b00 && g_we && g_size[1]) begin
                    ew = 1'b1; ewa = g_addr; ewd = g_wd;
                end
                check_val("mem_we", bus.mem_write_en, ew);
                if (ew) begin
                    check_val("mem_waddr", bus.mem_write_addr, ewa);
                    check_val("mem_wdata", bus.mem_write_data, ewd);
                    ref_mem[ewa[9:2]] = ewd;
                end

                rv = 2'b00;
                if (pl_v && pl_due == cyc) begin
                    rv[pl_port] = 1'b1;
                    if (pl_port) m_rd1 = pl_data; else m_rd0 = pl_data;
                    pl_v = 1'b0;
                end
                check_val("rvalid", {bus.r1_rvalid, bus.r0_rvalid}, rv);
                check_val("rdata", {bus.r1_rdata, bus.r0_rdata}, {m_rd1, m_rd0});

                if (gv != 2'b00) begin
                    m_last = gp;
                    if (log_en) begin
                        g_port_q.push_back(int'(gp));
                        g_cyc_q.push_back(cyc);
                    end
                    if (g_we && g_size[1]) begin
                        next_free = cyc + 1;
                    end else if (g_we) begin
                        pw_v = 1'b1; pw_due = cyc + 1; pw_addr = g_addr;
                        pw_data = ref_store(ref_mem[g_addr[9:2]], g_size, g_addr, g_wd);
                        next_free = cyc + 2;
                    end else begin
                        pl_v = 1'b1; pl_due = cyc + 2; pl_port = gp;
                        pl_data = ref_load(ref_mem[g_addr[9:2]], g_size, g_addr, g_sext);
                        next_free = cyc + 2;
                    end
                end
            end
        end
    end

    // Driver helpers; all start and end just after a rising edge.
    logic        cap_we;
    logic [31:0] cap_waddr, cap_wdata;

    task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] size,
                            input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_size = size;
            bus.r0_sext = sext; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_size = size;
            bus.r1_sext = sext; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, output int waits);
        logic g;
        g = 1'b0; waits = 0;
        set_port(p, 1'b1, we, size, sext, addr, wdata);
        for (int i = 0; i < 40 && !g; i++) begin
            @(negedge clk);
            g = (p == 0) ? bus.r0_gnt : bus.r1_gnt;
            if (g) begin
                cap_we = bus.mem_write_en; cap_waddr = bus.mem_write_addr; cap_wdata = bus.mem_write_data;
            end else waits++;
        end
        if (!g) check_val("gnt_timeout", g, 1'b1);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load_op(input int p, input logic [1:0] size, input logic sext, input logic [31:0] addr,
                           output logic [31:0] data, output int lat, output int waits);
        logic got;
        issue(p, 1'b0, size, sext, addr, 32'h0, waits);
        got = 1'b0; lat = 0; data = 32'h0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = (p == 0) ? bus.r0_rvalid : bus.r1_rvalid;
            if (got) data = (p == 0) ? bus.r0_rdata : bus.r1_rdata;
        end
        if (!got) check_val("rvalid_timeout", got, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic store_sub(input int p, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, output logic we, output logic [31:0] data);
        int w;
        issue(p, 1'b1, size, 1'b0, addr, wd, w);
        @(negedge clk);
        we = bus.mem_write_en; data = bus.mem_write_data;
        @(posedge clk); #1;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            logic        we, sext;
            logic [1:0]  size;
            logic [31:0] addr, wd, d;
            int          w, l;
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sext = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 127));
            wd   = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            if (we) issue(p, 1'b1, size, sext, addr, wd, w);
            else    load_op(p, size, sext, addr, d, l, w);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d, wd;
        logic        we;
        int          l, w;

        reset = 1'b1;
        mem_clear = 1'b1;
        set_port(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        check_val("first_gnt", {bus.r1_gnt, bus.r0_gnt}, 2'b01);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, w);
        repeat (3) @(posedge clk);
        #1;

        // Word store then load
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, w);
        check_val("wst_we", cap_we, 1'b1);
        check_val("wst_addr", cap_waddr, 32'h10);
        check_val("wst_data", cap_wdata, 32'hDEADBEEF);
        load_op(0, 2'd2, 1'b0, 32'h10, d, l, w);
        check_val("wld_data", d, 32'hDEADBEEF);
        check_val("wld_lat", l, 2);

        // Sub-word read-modify-write
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, w);
        store_sub(1, 2'd0, 32'h12, 32'h000000AA, we, wd);
        check_val("rmw_b_we", we, 1'b1);
        check_val("rmw_b_data", wd, 32'h11AA3344);
        store_sub(1, 2'd1, 32'h10, 32'h00005566, we, wd);
        check_val("rmw_h_we", we, 1'b1);
        check_val("rmw_h_data", wd, 32'h11AA5566);
        load_op(1, 2'd2, 1'b0, 32'h10, d, l, w);
        check_val("rmw_readback", d, 32'h11AA5566);

        // Sign extension
        issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80F07F01, w);
        load_op(0, 2'd0, 1'b1, 32'h23, d, l, w);
        check_val("sx_b3_s", d, 32'hFFFFFF80);
        load_op(0, 2'd0, 1'b0, 32'h23, d, l, w);
        check_val("sx_b3_z", d, 32'h00000080);
        load_op(1, 2'd1, 1'b1, 32'h22, d, l, w);
        check_val("sx_h1_s", d, 32'hFFFF80F0);
        load_op(1, 2'd0, 1'b1, 32'h21, d, l, w);
        check_val("sx_b1_s", d, 32'h0000007F);

        // Contention: both ports stream word loads
        log_en = 1'b1;
        fork
            begin : c0
                logic [31:0] d0;
                int l0, w0;
                for (int k = 0; k < 4; k++) begin
                    load_op(0, 2'd2, 1'b0, 32'h20, d0, l0, w0);
                    check_val("cont_d0", d0, 32'h80F07F01);
                end
            end
            begin : c1
                logic [31:0] d1;
                int l1, w1;
                for (int k = 0; k < 4; k++) begin
                    load_op(1, 2'd2, 1'b0, 32'h10, d1, l1, w1);
                    check_val("cont_d1", d1, 32'h11AA5566);
                end
            end
        join
        log_en = 1'b0;
        check_val("cont_count", g_port_q.size(), 8);
        for (int i = 1; i < g_port_q.size(); i++) begin
            check_val("cont_alt", g_port_q[i], 1 - g_port_q[i-1]);
            check_val("cont_gap", g_cyc_q[i] - g_cyc_q[i-1], 2);
        end

        // Reset during the RMW cycle of a byte store
        issue(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h01020304, w);
        issue(0, 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000EE, w);
        reset = 1'b1;
        @(negedge clk);
        check_val("rmw_rst_we", bus.mem_write_en, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        load_op(0, 2'd2, 1'b0, 32'h30, d, l, w);
        check_val("rmw_rst_word", d, 32'h01020304);
        check_val("rmw_rst_idle", w, 0);

        // Randomized traffic on both ports
        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            check_val("mem_final", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the word-organised data memory (32-bit words, word index = byte address >> 2, one-cycle registered read, full-word write enable). Two requesters (port 0: CPU load/store unit, port 1: debug/DMA) share the memory through round-robin arbitration. The block performs byte and halfword loads by lane extraction with optional sign extension, and byte and halfword stores by read-modify-write.

## Interface
- No parameters; all addresses and data are 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rN_req  in  1  port N (N = 0, 1) request valid; held until granted.
- rN_we  in  1  1 = store, 0 = load.
- rN_size  in  2  0 = byte, 1 = halfword, 2 or 3 = word.
- rN_sext  in  1  sign-extend sub-word load data; ignored for stores and words.
- rN_addr  in  32  byte address.
- rN_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rN_gnt  out  1  combinational; request accepted this cycle.
- rN_rvalid  out  1  registered; one-cycle pulse, load data valid.
- rN_rdata  out  32  registered load data; holds its value between pulses.
- mem_write_en  out  1  to memory write_en.
- mem_write_addr  out  32  to memory write_addr.
- mem_write_data  out  32  to memory write_data.
- mem_read_addr  out  32  to memory read_addr.
- mem_read_data  in  32  from memory; valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, LOAD, RMW. Reset state is IDLE.
- **IDLE**
  - If no request is pending, all mem_* outputs are 0 and no grant is issued.
  - Otherwise select one requester and assert its gnt for that cycle.
  - Latch port, sext, size and addr[1:0] in all cases; latch wdata for sub-word stores.
  - Word store: mem_write_en=1, write_addr=addr, write_data=wdata in the same cycle. FSM stays in IDLE.
  - Load: mem_read_addr=addr, then go to LOAD.
  - Byte or halfword store: mem_read_addr=addr, then go to RMW.
- **LOAD**
  - Extract from mem_read_data and register the result into the latched port's rdata. Set that port's rvalid for the next cycle.
  - Return to IDLE. No grant is issued in LOAD.
- **RMW**
  - Merge the latched wdata into the addressed lane(s) of mem_read_data.
  - Drive mem_write_en=1, mem_write_addr=latched addr, mem_write_data=merged word.
  - Return to IDLE. No grant is issued in RMW.
- Lane mapping is little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h]; addr[0] is ignored.
  - Words ignore addr[1:0]. Misalignment is never an error.
- Load extraction:
  - The selected lane is shifted to bit 0.
  - Upper bits are zero-filled, or copied from the lane MSB when sext=1.
- Arbitration:
  - A 1-bit last-grant pointer is updated on every grant.
  - With only one port requesting, that port is granted.
  - With both requesting, the port not granted last is granted.
  - Reset sets the pointer to 1, so port 0 wins the first contention.
- During any reset cycle:
  - gnt, rvalid and mem_write_en are 0; all mem_* outputs are 0.
  - rdata is 0; FSM goes to IDLE. An in-flight load or RMW is abandoned with no write and no rvalid.

## Timing
- Word store: accepted and written in grant cycle N; the memory updates at the end of N. Back-to-back word stores run at one per cycle.
- Load: granted in cycle N, FSM in LOAD in N+1, rvalid/rdata visible in N+2. The next grant is possible in N+2.
- Sub-word store: granted in N, merged write in N+1, next grant in N+2.
- A load granted in the cycle immediately after any write to the same word returns the new data.
- A requester must hold req/we/size/addr/wdata stable until gnt. Requests are evaluated only in IDLE.
- rvalid is never asserted on both ports in the same cycle.

## Test plan
- Reset: hold reset 2 cycles with both req=1 → gnt=0, rvalid=0, mem_write_en=0, rdata=0. After release, port 0 is granted first.
- Word path: port 0 stores 0xDEADBEEF to 0x10 (mem_write_en in grant cycle, write_addr=0x10), then loads 0x10 → rdata=0xDEADBEEF, rvalid exactly 2 cycles after gnt.
- Byte RMW: word 0x10=0x11223344; port 1 byte store 0xAA to 0x12 → write in the cycle after gnt with data 0x11AA3344. Halfword store 0x5566 to 0x10 → 0x11AA5566.
- Sign extension: word 0x80F07F01 at 0x20. Byte load 0x23 with sext=1 → 0xFFFFFF80. With sext=0 → 0x00000080. Halfword load 0x22 with sext=1 → 0xFFFF80F0. Byte load 0x21 with sext=1 → 0x0000007F.
- Contention: both ports continuously issue word loads → grants alternate 0,1,0,1, each 2 cycles apart, and each rvalid goes to the correct port with the correct data.
- Reset mid-RMW: assert reset in the RMW cycle of a byte store → no mem_write_en; memory word is unchanged; FSM is IDLE after release.
